fpu_requester: RTL and testbench
================================

FPU_REQUESTER -- requirements
Module: fpu_requester

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, watchdog limit in cycles (used only with FPU_REQ_TIMEOUT_EN).
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
- clock  input  1  single clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  1  command valid.
- req_ready  output  1  command accepted when req_valid && req_ready.
- req_op  input  3  operation; 3'b000 = OP_IDLE.
- req_a / req_b  input  DATA_WIDTH  operands.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
- rsp_result  output  DATA_WIDTH  FPU result.
- rsp_err  output  1  response is a timeout error.
- fpu_start  output  1  one-cycle start pulse to FPU.
- fpu_op  output  3  op to FPU.
- fpu_a / fpu_b  output  DATA_WIDTH  operands to FPU.
- fpu_result  input  DATA_WIDTH  FPU result.
- fpu_rdy  input  1  FPU result-ready strobe.
- busy  output  1  high whenever state != IDLE.

Function
REQ-004 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-005 req_ready SHALL be 1 only in IDLE.
REQ-006 Handshake in IDLE SHALL latch req_op/req_a/req_b into holding registers and go to ISSUE, or to RESP if req_op == OP_IDLE.
REQ-007 ISSUE SHALL assert fpu_start for exactly one cycle, then go to WAIT.
REQ-008 fpu_op/fpu_a/fpu_b SHALL be driven from holding registers and stay stable from ISSUE until the end of WAIT.
REQ-009 In WAIT, fpu_rdy == 1 SHALL capture fpu_result into rsp_result, clear rsp_err, and go to RESP.
REQ-010 An OP_IDLE command SHALL produce rsp_result = 0 and rsp_err = 0, and SHALL NOT pulse fpu_start.
REQ-011 In RESP, rsp_valid SHALL be 1 with rsp_result/rsp_err stable until rsp_ready.
REQ-012 rsp_valid && rsp_ready SHALL return the FSM to IDLE; the next command is accepted at the earliest on the following edge.
REQ-013 With a 31-cycle FPU, rsp_valid SHALL rise 32 edges after the accepting edge.
REQ-014 fpu_rdy SHALL be ignored in IDLE, ISSUE and RESP, with no state or output change.
REQ-015 req_valid SHALL be ignored outside IDLE; the command is not lost if the initiator holds it.

Reset
REQ-016 reset_n low SHALL immediately force state = IDLE and zero every output and holding register, except req_ready = 1 once in IDLE.
REQ-017 Reset mid-WAIT or mid-RESP SHALL discard the pending response; no rsp_valid after reset release until a new command is issued.

Configuration
REQ-018 With FPU_REQ_TIMEOUT_EN defined, WAIT SHALL count cycles.
REQ-019 With FPU_REQ_TIMEOUT_EN defined, if the count reaches TIMEOUT_CYCLES without fpu_rdy, the FSM SHALL go to RESP with rsp_err = 1 and rsp_result = 0.
REQ-020 If fpu_rdy arrives in the same cycle the timeout fires, fpu_rdy SHALL win.
REQ-021 Without FPU_REQ_TIMEOUT_EN, WAIT SHALL wait indefinitely, rsp_err SHALL be tied 0, and no counter logic SHALL exist.

Structure
REQ-022 Package fpu_pkg SHALL hold:
- the op encoding typedef (OP_IDLE = 3'b000);
- the FSM state enum;
- constant FPU_LATENCY = 31.
REQ-023 The watchdog SHALL be sub-module fpu_timeout_ctr (inputs clear/enable, output expired), instantiated only under FPU_REQ_TIMEOUT_EN.

Verification
REQ-024 Basic: op=3'b001, a=5, b=7 -> fpu_start pulses once, rsp_valid 32 edges after acceptance, rsp_result=12, rsp_err=0.
REQ-025 Backpressure: rsp_ready held low 10 cycles after rsp_valid -> rsp_result stays 12, req_ready stays 0, and a second req_valid is not accepted until the response handshake.
REQ-026 OP_IDLE: op=3'b000, a=1, b=2 -> no fpu_start, rsp_valid on the edge after acceptance, rsp_result=0.
REQ-027 Reset: reset_n low at WAIT cycle 15 -> all outputs 0 immediately, no rsp_valid after release, and a new request completes normally.
REQ-028 Timeout (FPU_REQ_TIMEOUT_EN, TIMEOUT_CYCLES=64, FPU stub never asserts fpu_rdy) -> rsp_valid with rsp_err=1, rsp_result=0, 64 cycles after WAIT entry.
REQ-029 Spurious strobe: fpu_rdy pulsed in IDLE -> no rsp_valid and state stays IDLE.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and constants for the FPU requester.
//   fpu_op_e    : 3-bit op encoding; OP_IDLE is a no-op that never reaches the FPU.
//                 The other codes are passed through to the FPU untouched.
//   fpu_state_e : requester FSM states.
//   FPU_LATENCY : nominal FPU latency in cycles (start pulse to result strobe).
package fpu_pkg;

  typedef enum logic [2:0] {
    OP_IDLE = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_MUL  = 3'b011,
    OP_DIV  = 3'b100,
    OP_SQRT = 3'b101,
    OP_CMP  = 3'b110,
    OP_CVT  = 3'b111
  } fpu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } fpu_state_e;

  localparam int FPU_LATENCY = 31;

  // True when the op bypasses the FPU entirely.
  function automatic logic is_nop(input logic [2:0] op);
    return (op == OP_IDLE);
  endfunction

endpackage

// File: rtl/fpu_timeout_ctr.sv
// fpu_timeout_ctr: watchdog counter for the WAIT state.
//   clock, reset_n : clock / async active-low reset
//   clear          : synchronous clear (held while the requester is not waiting)
//   enable         : count one per cycle
//   expired        : combinational, high in the cycle the count reaches its limit
// The counter is zero on the first WAIT cycle, so expired is high on the
// TIMEOUT_CYCLES-th WAIT cycle and the FSM leaves WAIT exactly
// TIMEOUT_CYCLES edges after entering it.
module fpu_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  assign expired = enable && (r_cnt == LIMIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable && !expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fpu_requester.sv
// fpu_requester: single-outstanding command bridge between a valid/ready
// initiator and a start/strobe FPU.
//   clock, reset_n           : clock / async active-low reset
//   req_valid/ready/op/a/b   : command channel (accepted only in IDLE)
//   rsp_valid/ready/result   : response channel, held stable until consumed
//   rsp_err                  : response is a watchdog timeout
//   fpu_start/op/a/b         : one-cycle start pulse plus held operands to FPU
//   fpu_result, fpu_rdy      : FPU result and its ready strobe (used only in WAIT)
//   busy                     : FSM not in IDLE
// Optional feature macro: FPU_REQ_TIMEOUT_EN adds a WAIT watchdog
// (fpu_timeout_ctr); without it WAIT is unbounded and rsp_err is tied low.
module fpu_requester
  import fpu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_err,
  output logic                  fpu_start,
  output logic [2:0]            fpu_op,
  output logic [DATA_WIDTH-1:0] fpu_a,
  output logic [DATA_WIDTH-1:0] fpu_b,
  input  logic [DATA_WIDTH-1:0] fpu_result,
  input  logic                  fpu_rdy,
  output logic                  busy
);

  fpu_state_e            r_state;
  logic [2:0]            r_op;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_result;
  logic                  r_fpu_start;
  logic                  r_busy;

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign fpu_start  = r_fpu_start;
  assign fpu_op     = r_op;
  assign fpu_a      = r_a;
  assign fpu_b      = r_b;
  assign busy       = r_busy;

`ifdef FPU_REQ_TIMEOUT_EN
  logic r_rsp_err;
  logic w_wait;
  logic w_timeout;

  assign rsp_err = r_rsp_err;
  assign w_wait  = (r_state == ST_WAIT);

  // Cleared in every non-WAIT state so each command gets a fresh budget.
  fpu_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (!w_wait),
    .enable  (w_wait),
    .expired (w_timeout)
  );
`else
  logic w_unused_timeout;

  assign rsp_err = 1'b0;
  // Watchdog limit is meaningless without the watchdog; kept so both builds
  // share one parameter list.
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_fpu_start  <= 1'b0;
      r_busy       <= 1'b0;
`ifdef FPU_REQ_TIMEOUT_EN
      r_rsp_err    <= 1'b0;
`endif
    end else begin
      // Start is a single-cycle pulse; only the accepting edge sets it.
      r_fpu_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op        <= req_op;
            r_a         <= req_a;
            r_b         <= req_b;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (is_nop(req_op)) begin
              // No-op bypasses the FPU and answers straight away with zero.
              r_state      <= ST_RESP;
              r_rsp_valid  <= 1'b1;
              r_rsp_result <= '0;
`ifdef FPU_REQ_TIMEOUT_EN
              r_rsp_err    <= 1'b0;
`endif
            end else begin
              r_state     <= ST_ISSUE;
              r_fpu_start <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // fpu_rdy is checked first so a result arriving on the timeout
          // cycle is still delivered.
          if (fpu_rdy) begin
            r_state      <= ST_RESP;
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= fpu_result;
`ifdef FPU_REQ_TIMEOUT_EN
            r_rsp_err    <= 1'b0;
          end else if (w_timeout) begin
            r_state      <= ST_RESP;
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b1;
`endif
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_requester.sv
// Scoreboard bench for fpu_requester: the command driver sets the expected
// response alongside each command, the monitor queues it on acceptance and
// checks latency, result and error flag when the response is consumed.
module tb_fpu_requester;
  import fpu_pkg::*;

  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = 3'b000;
  logic [DW-1:0] req_a = '0;
  logic [DW-1:0] req_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_result;
  logic          rsp_err;
  logic          fpu_start;
  logic [2:0]    fpu_op;
  logic [DW-1:0] fpu_a;
  logic [DW-1:0] fpu_b;
  logic [DW-1:0] fpu_result;
  logic          fpu_rdy;
  logic          busy;

  fpu_requester #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(64)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_result(fpu_result), .fpu_rdy(fpu_rdy), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- FPU stub: result strobe FPU_LATENCY cycles after start
  logic          stub_rdy = 1'b0;
  logic          spur_rdy = 1'b0;
  bit            stub_en = 1'b1;
  int            stub_cnt = 0;
  logic [DW-1:0] stub_res = '0;

  assign fpu_rdy = stub_rdy | spur_rdy;

  always @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stub_cnt   = 0;
      stub_rdy   = 1'b0;
      fpu_result = '0;
    end else begin
      stub_rdy = 1'b0;
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          stub_rdy   = 1'b1;
          fpu_result = stub_res;
        end
      end
      if (fpu_start && stub_en) begin
        stub_cnt = FPU_LATENCY;
        case (fpu_op)
          3'd1:    stub_res = fpu_a + fpu_b;
          3'd2:    stub_res = fpu_a - fpu_b;
          3'd3:    stub_res = fpu_a * fpu_b;
          default: stub_res = fpu_a ^ fpu_b;
        endcase
      end
    end
  end

  // ---------------- scoreboard
  typedef struct {
    logic [DW-1:0] res;
    logic          err;
    int            lat;   // edges from accepting edge to rsp_valid rise
    int            acc;   // cycle number of the accepting edge
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] cur_res = '0;
  logic          cur_err = 1'b0;
  int            cur_lat = 0;
  int            cyc = 0;
  logic          prev_v = 1'b0;
  int            n_start = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset_n) begin
      prev_v = 1'b0;
    end else begin
      if (fpu_start) n_start++;
      if (req_valid && req_ready)
        sb_q.push_back('{res: cur_res, err: cur_err, lat: cur_lat, acc: cyc + 1});
      if (rsp_valid && !prev_v) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp: rsp_valid=1 result=%0d with no command outstanding", rsp_result);
        end else begin
          check("rsp_latency", cyc - sb_q[0].acc, sb_q[0].lat);
        end
      end
      if (rsp_valid && rsp_ready && sb_q.size() > 0) begin
        check("rsp_result", rsp_result, sb_q[0].res);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, sb_q[0].err});
        void'(sb_q.pop_front());
      end
      prev_v = rsp_valid;
    end
  end

  // ---------------- driver helpers
  task automatic send(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] res, input logic err, input int lat,
                      output int waited);
    bit ok = 1'b0;
    waited  = 0;
    cur_res = res;
    cur_err = err;
    cur_lat = lat;
    req_op  = op;
    req_a   = a;
    req_b   = b;
    req_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (req_ready) begin
        ok = 1'b1;
        waited = i;
        break;
      end
    end
    check("req_accepted", {31'd0, ok}, 32'd1);
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (rsp_valid && rsp_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("rsp_done", {31'd0, ok}, 32'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_result"}, rsp_result, 32'd0);
    check({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    check({tag, "_fpu_start"}, {31'd0, fpu_start}, 32'd0);
    check({tag, "_fpu_op"}, {29'd0, fpu_op}, 32'd0);
    check({tag, "_fpu_a"}, fpu_a, 32'd0);
    check({tag, "_fpu_b"}, fpu_b, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // ---------------- stimulus
  initial begin
    int w;
    int s0;
    bit seen;

    // Reset state
    #12;
    check_reset_outputs("reset");
    @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Basic add: 5 + 7
    s0 = n_start;
    send(3'b001, 32'd5, 32'd7, 32'd12, 1'b0, 32, w);
    repeat (3) @(negedge clock);
    check("wait_fpu_op", {29'd0, fpu_op}, 32'd1);
    check("wait_fpu_a", fpu_a, 32'd5);
    check("wait_fpu_b", fpu_b, 32'd7);
    check("wait_busy", {31'd0, busy}, 32'd1);
    check("wait_req_ready", {31'd0, req_ready}, 32'd0);
    wait_done();
    check("basic_start_pulses", n_start - s0, 32'd1);

    // Backpressure with a second command held during RESP
    rsp_ready = 1'b0;
    send(3'b001, 32'd5, 32'd7, 32'd12, 1'b0, 32, w);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("bp_rsp_valid_seen", {31'd0, seen}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      if (i == 0) begin
        cur_res = 32'd17; cur_err = 1'b0; cur_lat = 32;
        req_op = 3'b010; req_a = 32'd20; req_b = 32'd3; req_valid = 1'b1;
      end
      @(negedge clock);
      check("bp_result_hold", rsp_result, 32'd12);
      check("bp_rsp_valid_hold", {31'd0, rsp_valid}, 32'd1);
      check("bp_req_ready_low", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clock);
    #1 rsp_ready = 1'b1;
    send(3'b010, 32'd20, 32'd3, 32'd17, 1'b0, 32, w);
    // Handshake negedge is still RESP; IDLE accepts on the very next cycle.
    check("bp_accept_delay", w, 32'd1);
    wait_done();

    // No-op command bypasses the FPU
    s0 = n_start;
    send(3'b000, 32'd1, 32'd2, 32'd0, 1'b0, 0, w);
    wait_done();
    check("nop_start_pulses", n_start - s0, 32'd0);

    // Reset in the middle of WAIT
    send(3'b001, 32'd5, 32'd7, 32'd12, 1'b0, 32, w);
    repeat (15) @(posedge clock);
    #1 reset_n = 1'b0;
    sb_q.delete();
    #1;
    check_reset_outputs("midwait_reset");
    @(posedge clock);
    #1 reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (rsp_valid) seen = 1'b1;
    end
    check("no_rsp_after_reset", {31'd0, seen}, 32'd0);
    send(3'b011, 32'd6, 32'd7, 32'd42, 1'b0, 32, w);
    wait_done();

    // Spurious fpu_rdy strobe in IDLE
    @(posedge clock);
    #1 spur_rdy = 1'b1;
    @(posedge clock);
    #1 spur_rdy = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (rsp_valid || busy || !req_ready) seen = 1'b1;
    end
    check("spurious_rdy_ignored", {31'd0, seen}, 32'd0);

`ifdef FPU_REQ_TIMEOUT_EN
    // Watchdog: FPU never answers; error 64 edges after WAIT entry
    stub_en = 1'b0;
    send(3'b001, 32'd1, 32'd1, 32'd0, 1'b1, 65, w);
    wait_done();
    stub_en = 1'b1;
`endif

    repeat (3) @(posedge clock);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
